uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- DATA_WIDTH, 8, width of one received character.
- DEPTH_LOG2, 4, log2 of the number of FIFO entries (16 by default).
- THRESHOLD, 8, fill level at which thresh_irq asserts; legal range 1..2^DEPTH_LOG2.

REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- rx_data, input, DATA_WIDTH, character from the UART receiver.
- rx_ready, input, 1, single-cycle strobe: rx_data is valid this cycle (push).
- rd_data, output, DATA_WIDTH, oldest stored character (head).
- rd_valid, output, 1, FIFO holds at least one entry.
- rd_en, input, 1, pop the head this cycle (AXI-lite RX data register read).
- flush, input, 1, discard all contents.
- level, output, DEPTH_LOG2+1, current entry count.
- full, output, 1, level equals 2^DEPTH_LOG2.
- thresh_irq, output, 1, level >= THRESHOLD.
- overrun, output, 1, sticky flag: a character was dropped.
- overrun_clr, input, 1, clears overrun.

Function
REQ-004 Storage SHALL be a circular buffer of 2^DEPTH_LOG2 entries with write/read pointers of width DEPTH_LOG2 that wrap modulo 2^DEPTH_LOG2.
REQ-005 level SHALL be a registered counter: +1 on an accepted push only, -1 on an accepted pop only, unchanged when both or neither occur.
REQ-006 A push SHALL be accepted when rx_ready=1 and (full=0, or an accepted pop occurs in the same cycle).
REQ-007 A pop SHALL be accepted when rd_en=1 and rd_valid=1; rd_en with rd_valid=0 SHALL be ignored with no pointer or level change.
REQ-008 The FIFO SHALL be first-word-fall-through: rd_data SHALL equal the head entry whenever rd_valid=1; rd_data SHALL be don't-care when rd_valid=0.
REQ-009 Latency: a push accepted in cycle N SHALL give rd_valid=1 and level updated in cycle N+1.
REQ-010 When empty with rx_ready=1 and rd_en=1 in the same cycle: push accepted, pop ignored, level=1 next cycle.
REQ-011 When full with rx_ready=1 and rd_en=1 in the same cycle: both accepted, level stays 2^DEPTH_LOG2, and the new character is written to the freed slot.
REQ-012 When full with rx_ready=1 and no pop: the character SHALL be dropped, with pointers and level unchanged.
REQ-013 flush SHALL have priority over push and pop: next cycle, pointers=0 and level=0; any simultaneous push or pop is discarded. flush SHALL NOT clear overrun.
REQ-014 rd_valid, full and thresh_irq SHALL be derived combinationally from the registered level only.
REQ-015 Stored data SHALL NOT be altered except by an accepted push to that slot.

Reset
REQ-016 While rst=1 (sampled on clk): pointers=0, level=0, overrun=0; hence rd_valid=0, full=0, thresh_irq=0.
REQ-017 Reset asserted mid-operation SHALL discard all contents within one cycle; memory contents need not be cleared.
REQ-018 rst SHALL have priority over flush, push, pop and overrun_clr.

Configuration
REQ-019 With macro UART_RX_FIFO_OVERRUN_EN defined: overrun SHALL be set the cycle after a dropped push (REQ-012) and held until overrun_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-020 Without UART_RX_FIFO_OVERRUN_EN: overrun SHALL be constant 0, overrun_clr SHALL be ignored, and drop behaviour (REQ-012) SHALL be unchanged.

Verification
REQ-021 Reset, then push 0x41,0x42,0x43 on separate cycles -> level=3; three pops return 0x41,0x42,0x43 in order; rd_valid=0 after the last pop.
REQ-022 Push 16 characters (DEPTH_LOG2=4) -> full=1, thresh_irq=1 from level 8; a 17th push of 0xEE is dropped; overrun=1 (macro on) or 0 (macro off); popped data shows no 0xEE.
REQ-023 Full FIFO, rx_ready=1 with rd_en=1 in the same cycle -> level stays 16; the new character is read out as the 16th pop after the old head.
REQ-024 Empty FIFO, rx_ready=1 (0x5A) with rd_en=1 -> level=1 and rd_data=0x5A next cycle.
REQ-025 Level 5: flush with a simultaneous push -> level=0, rd_valid=0 next cycle; overrun unchanged. Then rst asserted with level 3 -> level=0 and overrun=0.
REQ-026 Macro on, overrun set: overrun_clr=1 in the same cycle as a dropped push -> overrun stays 1; overrun_clr alone next cycle -> overrun=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver / register reader and the RX FIFO.
// slave = FIFO side, master = the logic that pushes, pops and watches flags.
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_en;
    logic                  flush;
    logic [DEPTH_LOG2:0]   level;
    logic                  full;
    logic                  thresh_irq;
    logic                  overrun;
    logic                  overrun_clr;

    modport slave (
        input  rx_data, rx_ready, rd_en, flush, overrun_clr,
        output rd_data, rd_valid, level, full, thresh_irq, overrun
    );

    modport master (
        output rx_data, rx_ready, rd_en, flush, overrun_clr,
        input  rd_data, rd_valid, level, full, thresh_irq, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO for a UART, with level/threshold flags.
// Define UART_RX_FIFO_OVERRUN_EN to enable the sticky overrun flag.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int THRESHOLD  = 8
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_fifo_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_THRESH = (DEPTH_LOG2+1)'(THRESHOLD);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;

    logic w_full;
    logic w_rd_valid;
    logic w_pop;
    logic w_push;

    // Flags come only from the registered level so they never glitch on inputs.
    assign w_full     = (r_level == LVL_FULL);
    assign w_rd_valid = (r_level != '0);
    assign w_pop      = bus.rd_en & w_rd_valid;
    assign w_push     = bus.rx_ready & (~w_full | w_pop);

    assign bus.rd_data    = r_mem[r_rd_ptr];
    assign bus.rd_valid   = w_rd_valid;
    assign bus.full       = w_full;
    assign bus.thresh_irq = (r_level >= LVL_THRESH);
    assign bus.level      = r_level;

    // Storage has no reset; a push discarded by rst or flush must not touch it.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic w_drop;
    logic r_overrun;

    // A push lost to flush is discarded, not dropped for lack of space.
    assign w_drop      = bus.rx_ready & w_full & ~w_pop & ~bus.flush;
    assign bus.overrun = r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end
`else
    // overrun_clr is consumed here only so it is not left dangling; result is 0.
    assign bus.overrun = 1'b0 & bus.overrun_clr;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int TH    = 8;
    localparam int DEPTH = 1 << DL;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    logic [DW-1:0] q[$];
    logic          m_ov;

    uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bif ();

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .THRESHOLD(TH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"},  32'(bif.level),      32'(q.size()));
        check({tag, ".valid"},  32'(bif.rd_valid),   32'(q.size() != 0));
        check({tag, ".full"},   32'(bif.full),       32'(q.size() == DEPTH));
        check({tag, ".thresh"}, 32'(bif.thresh_irq), 32'(q.size() >= TH));
        check({tag, ".ovr"},    32'(bif.overrun),    32'(m_ov));
        if (q.size() != 0) begin
            check({tag, ".data"}, 32'(bif.rd_data), 32'(q[0]));
        end
    endtask

    // One clock: drive inputs, advance the model by the same rules, compare.
    task automatic step(input string tag, input logic push, input logic [DW-1:0] d,
                        input logic pop, input logic fl, input logic clr, input logic r);
        logic pop_ok;
        logic push_ok;
        logic drop;
        bif.rx_ready    = push;
        bif.rx_data     = d;
        bif.rd_en       = pop;
        bif.flush       = fl;
        bif.overrun_clr = clr;
        rst             = r;
        @(posedge clk);
        #1;
        drop = 1'b0;
        if (r) begin
            q.delete();
        end else if (fl) begin
            q.delete();
        end else begin
            pop_ok  = pop && (q.size() > 0);
            push_ok = push && ((q.size() < DEPTH) || pop_ok);
            drop    = push && !push_ok;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
`ifdef UART_RX_FIFO_OVERRUN_EN
        if (r)         m_ov = 1'b0;
        else if (drop) m_ov = 1'b1;
        else if (clr)  m_ov = 1'b0;
`else
        m_ov = 1'b0;
`endif
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push1(input string tag, input logic [DW-1:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1(input string tag);
        step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("post_reset");
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_ov     = 1'b0;
        rst      = 1'b1;
        bif.rx_ready = 1'b0; bif.rx_data = '0; bif.rd_en = 1'b0;
        bif.flush = 1'b0; bif.overrun_clr = 1'b0;

        // Basic ordering
        do_reset();
        push1("p41", 8'h41);
        push1("p42", 8'h42);
        push1("p43", 8'h43);
        check("lvl3", 32'(bif.level), 32'd3);
        check("head41", 32'(bif.rd_data), 32'h41);
        pop1("pop1");
        check("head42", 32'(bif.rd_data), 32'h42);
        pop1("pop2");
        check("head43", 32'(bif.rd_data), 32'h43);
        pop1("pop3");
        check("empty_valid", 32'(bif.rd_valid), 32'd0);
        pop1("pop_empty");

        // Fill to full, drop 0xEE, drain
        for (int i = 0; i < DEPTH; i++) push1("fill", DW'(8'h10 + i));
        check("full16", 32'(bif.full), 32'd1);
        push1("drop_ee", 8'hEE);
        check("lvl_after_drop", 32'(bif.level), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check("no_ee", 32'(bif.rd_data == 8'hEE), 32'd0);
            pop1("drain");
        end
        do_reset();

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push1("fill2", DW'($urandom_range(0, 8'hFD)));
        step("full_pp", 1'b1, 8'hA7, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_pp_lvl", 32'(bif.level), 32'd16);
        for (int i = 0; i < DEPTH; i++) pop1("drain2");
        check("drain2_empty", 32'(bif.level), 32'd0);

        // Empty with simultaneous push and pop
        step("empty_pp", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        check("empty_pp_data", 32'(bif.rd_data), 32'h5A);
        pop1("drain3");

        // Flush with push, then reset mid-operation
        for (int i = 0; i < DEPTH; i++) push1("fill3", DW'(i));
        push1("drop2", 8'h99);
        pop1("pop_some");
        for (int i = 0; i < 10; i++) pop1("to5");
        check("lvl5", 32'(bif.level), 32'd5);
        step("flush_push", 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        check("flush_valid", 32'(bif.rd_valid), 32'd0);
        for (int i = 0; i < 3; i++) push1("to3", DW'(8'hC0 + i));
        step("rst_mid", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_ovr", 32'(bif.overrun), 32'd0);
        idle("after_rst");

        // Overrun set beats clear, then clear alone
        for (int i = 0; i < DEPTH; i++) push1("fill4", DW'(i * 3));
        push1("drop3", 8'h01);
        step("set_clr", 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
        step("clr_only", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovr_cleared", 32'(bif.overrun), 32'd0);
        do_reset();

        // Random traffic, biased toward hovering around full and threshold
        for (int i = 0; i < 3000; i++) begin
            int unsigned bias;
            bias = (i / 500) % 2 == 0 ? 70 : 35;
            step("rand",
                 $urandom_range(0, 99) < bias,
                 DW'($urandom),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 199) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 499) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
